// File: rtl/fetch_ctrl.sv
// LC-3b fetch/decode boundary controller: imem read handshake, PC/IR load strobes,
// one-entry skid register for decode stalls, branch redirect and perf counters.
module fetch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_resp,
  input  logic [15:0]      imem_rdata,
  input  logic             stall,
  input  logic             flush,
  output logic             imem_read,
  output logic             pc_load,
  output logic             pc_mux_sel,
  output logic             ir_load,
  output logic [15:0]      ir_in,
  output logic             ir_valid,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ir_valid_q, ir_valid_d;
  logic [15:0]       skid_q, skid_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d       = state_q;
    ir_valid_d    = ir_valid_q;
    skid_d        = skid_q;
    fetch_count_d = fetch_count_q;
    stall_count_d = (ir_valid_q && stall) ? sat_inc(stall_count_q) : stall_count_q;
    imem_read     = 1'b0;
    pc_load       = 1'b0;
    pc_mux_sel    = 1'b0;
    ir_load       = 1'b0;
    ir_in         = imem_rdata;

    unique case (state_q)
      FETCH: begin
        imem_read = 1'b1;
        if (flush) begin
          pc_load    = 1'b1;
          pc_mux_sel = 1'b1;
          ir_valid_d = 1'b0;
          state_d    = REDIR;
        end else if (imem_resp) begin
          pc_load       = 1'b1;
          fetch_count_d = fetch_count_q + CNT_W'(1);
          if (!stall) begin
            ir_load    = 1'b1;
            ir_valid_d = 1'b1;
          end else begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end
        end else if (!stall) begin
          ir_valid_d = 1'b0;
        end
      end
      HOLD: begin
        ir_in = skid_q;
        if (flush) begin
          pc_load    = 1'b1;
          pc_mux_sel = 1'b1;
          ir_valid_d = 1'b0;
          state_d    = REDIR;
        end else if (!stall) begin
          ir_load    = 1'b1;
          ir_valid_d = 1'b1;
          state_d    = FETCH;
        end
      end
      REDIR: begin
        ir_valid_d = 1'b0;
        if (flush) begin
          // A second redirect supersedes the first; the newest target wins.
          pc_load    = 1'b1;
          pc_mux_sel = 1'b1;
        end else begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // Reset silences every strobe so an outstanding read is abandoned.
    if (reset) begin
      imem_read  = 1'b0;
      pc_load    = 1'b0;
      pc_mux_sel = 1'b0;
      ir_load    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      ir_valid_q    <= 1'b0;
      skid_q        <= '0;
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ir_valid_q    <= ir_valid_d;
      skid_q        <= skid_d;
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ir_valid    = ir_valid_q;
  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl; a second narrow-counter instance exercises
// stall_count saturation and fetch_count wrap in a short run.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, imem_resp, stall, flush;
  logic [15:0] imem_rdata;
  logic        imem_read, pc_load, pc_mux_sel, ir_load, ir_valid;
  logic [15:0] ir_in, fetch_count, stall_count;
  logic        s_imem_read, s_pc_load, s_pc_mux_sel, s_ir_load, s_ir_valid;
  logic [15:0] s_ir_in;
  logic [3:0]  s_fetch_count, s_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .imem_read(imem_read), .pc_load(pc_load),
    .pc_mux_sel(pc_mux_sel), .ir_load(ir_load), .ir_in(ir_in), .ir_valid(ir_valid),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  fetch_ctrl #(.CNT_W(4)) u_small (
    .clk(clk), .reset(reset), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .imem_read(s_imem_read), .pc_load(s_pc_load),
    .pc_mux_sel(s_pc_mux_sel), .ir_load(s_ir_load), .ir_in(s_ir_in), .ir_valid(s_ir_valid),
    .fetch_count(s_fetch_count), .stall_count(s_stall_count)
  );

  // Apply inputs at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic r, input logic resp, input logic [15:0] rd,
                       input logic st, input logic fl);
    @(negedge clk);
    reset = r; imem_resp = resp; imem_rdata = rd; stall = st; flush = fl;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 16'h9999, 0, 0);
    drive(1, 1, 16'h9999, 0, 0);
    checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL rst_imem_read got %b exp 0", imem_read); end
    checks++; if ({pc_load, pc_mux_sel, ir_load} !== 3'b000) begin errors++; $display("FAIL rst_loads got %b exp 000", {pc_load, pc_mux_sel, ir_load}); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_ir_valid got %b exp 0", ir_valid); end
    checks++; if (fetch_count !== 16'd0 || stall_count !== 16'd0) begin errors++; $display("FAIL rst_counts got %h/%h exp 0/0", fetch_count, stall_count); end
  endtask

  task automatic test_fetch();
    drive(0, 1, 16'h1234, 0, 0);
    checks++; if ({imem_read, ir_load, pc_load, pc_mux_sel} !== 4'b1110) begin errors++; $display("FAIL fetch1_strobes got %b exp 1110", {imem_read, ir_load, pc_load, pc_mux_sel}); end
    checks++; if (ir_in !== 16'h1234) begin errors++; $display("FAIL fetch1_ir_in got %h exp 1234", ir_in); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL fetch1_ir_valid got %b exp 0", ir_valid); end
    drive(0, 1, 16'h5678, 0, 0);
    checks++; if ({ir_load, pc_load, pc_mux_sel} !== 3'b110) begin errors++; $display("FAIL fetch2_strobes got %b exp 110", {ir_load, pc_load, pc_mux_sel}); end
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL fetch2_ir_valid got %b exp 1", ir_valid); end
    checks++; if (ir_in !== 16'h5678) begin errors++; $display("FAIL fetch2_ir_in got %h exp 5678", ir_in); end
    drive(0, 0, 16'h0000, 0, 0);
    checks++; if (fetch_count !== 16'd2) begin errors++; $display("FAIL fetch_count got %0d exp 2", fetch_count); end
    checks++; if ({ir_load, pc_load} !== 2'b00) begin errors++; $display("FAIL fetch_idle_loads got %b exp 00", {ir_load, pc_load}); end
  endtask

  task automatic test_stall();
    drive(0, 1, 16'h1111, 0, 0);
    drive(0, 1, 16'hABCD, 1, 0);
    checks++; if ({imem_read, ir_load, pc_load, pc_mux_sel} !== 4'b1010) begin errors++; $display("FAIL stall_resp_strobes got %b exp 1010", {imem_read, ir_load, pc_load, pc_mux_sel}); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 16'h0000, 1, 0);
      checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL hold_imem_read[%0d] got %b exp 0", i, imem_read); end
      checks++; if (ir_in !== 16'hABCD) begin errors++; $display("FAIL hold_ir_in[%0d] got %h exp abcd", i, ir_in); end
      checks++; if (ir_load !== 1'b0) begin errors++; $display("FAIL hold_ir_load[%0d] got %b exp 0", i, ir_load); end
    end
    drive(0, 0, 16'h0000, 0, 0);
    checks++; if ({ir_load, imem_read, pc_load} !== 3'b100) begin errors++; $display("FAIL hold_release got %b exp 100", {ir_load, imem_read, pc_load}); end
    checks++; if (ir_in !== 16'hABCD) begin errors++; $display("FAIL hold_release_ir_in got %h exp abcd", ir_in); end
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL stall_count got %0d exp 3", stall_count); end
    drive(0, 0, 16'h0000, 0, 0);
    checks++; if (imem_read !== 1'b1 || ir_valid !== 1'b1) begin errors++; $display("FAIL after_hold got read=%b valid=%b exp 1/1", imem_read, ir_valid); end
    checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL stall_fetch_count got %0d exp 4", fetch_count); end
  endtask

  task automatic test_flush_fetch();
    drive(0, 1, 16'h0F0F, 0, 1);
    checks++; if ({pc_load, pc_mux_sel, ir_load, imem_read} !== 4'b1101) begin errors++; $display("FAIL flushf_strobes got %b exp 1101", {pc_load, pc_mux_sel, ir_load, imem_read}); end
    drive(0, 0, 16'h0000, 0, 0);
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL flushf_ir_valid got %b exp 0", ir_valid); end
    checks++; if (imem_read !== 1'b0 || pc_load !== 1'b0) begin errors++; $display("FAIL flushf_redir got read=%b pcl=%b exp 0/0", imem_read, pc_load); end
    checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL flushf_fetch_count got %0d exp 4", fetch_count); end
    drive(0, 0, 16'h0000, 0, 0);
    checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL flushf_resume got %b exp 1", imem_read); end
  endtask

  task automatic test_flush_hold();
    drive(0, 1, 16'hABCD, 1, 0);
    drive(0, 0, 16'h0000, 1, 1);
    checks++; if ({pc_load, pc_mux_sel, ir_load, imem_read} !== 4'b1100) begin errors++; $display("FAIL flushh_strobes got %b exp 1100", {pc_load, pc_mux_sel, ir_load, imem_read}); end
    drive(0, 0, 16'h0000, 0, 0);
    checks++; if (imem_read !== 1'b0 || ir_load !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL flushh_redir got read=%b load=%b valid=%b exp 0/0/0", imem_read, ir_load, ir_valid); end
    drive(0, 1, 16'h2222, 0, 0);
    checks++; if (ir_in !== 16'h2222 || ir_load !== 1'b1) begin errors++; $display("FAIL flushh_next got ir_in=%h load=%b exp 2222/1", ir_in, ir_load); end
    drive(0, 0, 16'h0000, 1, 0);
    checks++; if (ir_valid !== 1'b1 || fetch_count !== 16'd6) begin errors++; $display("FAIL flushh_after got valid=%b fc=%0d exp 1/6", ir_valid, fetch_count); end
    checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL flushh_no_hold got %b exp 1", imem_read); end
  endtask

  task automatic test_double_flush();
    drive(0, 0, 16'h0000, 0, 1);
    checks++; if ({pc_load, pc_mux_sel} !== 2'b11) begin errors++; $display("FAIL dflush1 got %b exp 11", {pc_load, pc_mux_sel}); end
    drive(0, 0, 16'h0000, 0, 1);
    checks++; if ({pc_load, pc_mux_sel, imem_read} !== 3'b110) begin errors++; $display("FAIL dflush2 got %b exp 110", {pc_load, pc_mux_sel, imem_read}); end
    drive(0, 0, 16'h0000, 0, 0);
    checks++; if ({imem_read, pc_load, pc_mux_sel} !== 3'b000) begin errors++; $display("FAIL dflush_redir got %b exp 000", {imem_read, pc_load, pc_mux_sel}); end
    drive(0, 0, 16'h0000, 0, 0);
    checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL dflush_resume got %b exp 1", imem_read); end
  endtask

  task automatic test_counters();
    for (int i = 0; i < 11; i++) drive(0, 1, 16'h3000 + 16'(i), 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 16'h0000, 1, 0);
    checks++; if (fetch_count !== 16'd17) begin errors++; $display("FAIL cnt_fetch got %0d exp 17", fetch_count); end
    checks++; if (s_fetch_count !== 4'd1) begin errors++; $display("FAIL cnt_fetch_wrap got %0d exp 1", s_fetch_count); end
    checks++; if (stall_count !== 16'd23) begin errors++; $display("FAIL cnt_stall got %0d exp 23", stall_count); end
    checks++; if (s_stall_count !== 4'hF) begin errors++; $display("FAIL cnt_stall_sat got %h exp f", s_stall_count); end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 16'h0000, 1, 0);
    checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL rstmid_read got %b exp 0", imem_read); end
    drive(0, 0, 16'h0000, 1, 0);
    checks++; if (ir_valid !== 1'b0 || fetch_count !== 16'd0 || stall_count !== 16'd0 || s_stall_count !== 4'd0) begin errors++; $display("FAIL rstmid_state got v=%b fc=%h sc=%h ssc=%h exp 0", ir_valid, fetch_count, stall_count, s_stall_count); end
    checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL rstmid_fetch got %b exp 1", imem_read); end
    drive(0, 1, 16'hBBBB, 1, 0);
    drive(1, 0, 16'h0000, 0, 0);
    checks++; if ({ir_load, pc_load, imem_read} !== 3'b000) begin errors++; $display("FAIL rsthold_strobes got %b exp 000", {ir_load, pc_load, imem_read}); end
    drive(0, 0, 16'h0000, 0, 0);
    checks++; if (imem_read !== 1'b1 || ir_load !== 1'b0) begin errors++; $display("FAIL rsthold_fetch got read=%b load=%b exp 1/0", imem_read, ir_load); end
    checks++; if (ir_valid !== 1'b0 || fetch_count !== 16'd0) begin errors++; $display("FAIL rsthold_state got v=%b fc=%h exp 0/0", ir_valid, fetch_count); end
  endtask

  initial begin
    reset = 1'b1; imem_resp = 1'b0; imem_rdata = 16'h0; stall = 1'b0; flush = 1'b0;
    test_reset();
    test_fetch();
    test_stall();
    test_flush_fetch();
    test_flush_hold();
    test_double_flush();
    test_counters();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
